// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types, constants and address-legality helper for the
//               data-memory arbiter and its clients.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam int DMEM_ADDR_W     = 64;
    localparam int DMEM_DATA_W     = 64;
    localparam int DMEM_DEPTH      = 1024;
    localparam int WORD_BYTES      = 8;
    localparam int ADDR_ALIGN_BITS = 3;

    // Request as seen by the memory after arbitration.
    typedef struct packed {
        logic                   we;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
    } mem_req_t;

    // Response payload returned to the winning requester.
    typedef struct packed {
        logic                   err;
        logic [DMEM_DATA_W-1:0] rdata;
    } mem_resp_t;

    // An access is illegal when it is not word aligned or lies at/after limit.
    function automatic logic addr_illegal(
        input logic [DMEM_ADDR_W-1:0] addr,
        input logic [DMEM_ADDR_W-1:0] limit
    );
        return (addr[ADDR_ALIGN_BITS-1:0] != '0) || (addr >= limit);
    endfunction

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_if
// Description : Request/response handshake and memory-side bus of the
//               data-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W
);

    // Requester side
    logic [1:0]        req_valid;
    logic [1:0]        req_we;
    logic [ADDR_W-1:0] req_addr0;
    logic [ADDR_W-1:0] req_addr1;
    logic [DATA_W-1:0] req_wdata0;
    logic [DATA_W-1:0] req_wdata1;
    logic [1:0]        req_ready;
    logic [1:0]        resp_valid;
    logic              resp_err;
    logic [DATA_W-1:0] resp_rdata;

    // Memory side
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter view
    modport slave (
        input  req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
        input  mem_rdata,
        output req_ready, resp_valid, resp_err, resp_rdata,
        output mem_read, mem_write, mem_addr, mem_wdata
    );

    // Requester view
    modport master (
        output req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
        input  req_ready, resp_valid, resp_err, resp_rdata
    );

    // Memory view
    modport mem (
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface : dmem_arbiter_if
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way round-robin arbiter. Grant is combinational; the
//               last-granted pointer moves only when the caller reports that
//               the grant was consumed (advance).
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic [1:0] req,
    input  wire logic       advance,
    output logic      [1:0] grant
);

    // Last port granted; resets to 1 so port 0 wins the first contention.
    logic r_last_grant;

    // Single requester wins outright; on contention the other-than-last wins.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = r_last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Remember the winner of every consumed grant; hold while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
        end else if (advance && (grant != 2'b00)) begin
            r_last_grant <= grant[1];
        end
    end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Arbitrates instruction-fetch (port 0) and load/store (port 1)
//               requests onto the single-port data memory, rejects misaligned
//               or out-of-range accesses, and returns a registered response
//               one cycle after each accepted request.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W,
    parameter int DEPTH  = DMEM_DEPTH
) (
    input  wire logic     clk,
    input  wire logic     rst,
    dmem_arbiter_if.slave bus
);

    // First illegal byte address (one past the last word).
    localparam logic [DMEM_ADDR_W-1:0] c_addr_limit =
        DMEM_ADDR_W'(DEPTH) << ADDR_ALIGN_BITS;

    logic [1:0] w_req_valid;
    logic [1:0] w_grant;
    logic       w_sel;
    logic       w_hs;
    logic       w_err;
    logic       w_do_mem;
    mem_req_t   w_req;
    mem_resp_t  w_resp_d;

    logic [1:0] r_resp_valid;
    mem_resp_t  r_resp;

    // Nothing may be granted while reset is held, so mask requests first.
    assign w_req_valid = rst ? 2'b00 : bus.req_valid;

    rr_arbiter2 u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (w_req_valid),
        .advance (w_hs),
        .grant   (w_grant)
    );

    // Select the winning request and decide whether it may touch memory.
    // With no grant the mux falls through to port 0.
    always_comb begin
        w_sel          = w_grant[1];
        w_hs           = (w_grant != 2'b00);
        w_req.we       = w_sel ? bus.req_we[1] : bus.req_we[0];
        w_req.addr     = w_sel ? DMEM_ADDR_W'(bus.req_addr1)  : DMEM_ADDR_W'(bus.req_addr0);
        w_req.wdata    = w_sel ? DMEM_DATA_W'(bus.req_wdata1) : DMEM_DATA_W'(bus.req_wdata0);
        w_err          = addr_illegal(w_req.addr, c_addr_limit);
        w_do_mem       = w_hs && !w_err;
        w_resp_d.err   = w_hs && w_err;
        w_resp_d.rdata = (w_do_mem && !w_req.we) ? DMEM_DATA_W'(bus.mem_rdata)
                                                 : '0;
    end

    assign bus.req_ready = w_grant;
    assign bus.mem_read  = w_do_mem && !w_req.we;
    assign bus.mem_write = w_do_mem &&  w_req.we;
    assign bus.mem_addr  = ADDR_W'(w_req.addr);
    assign bus.mem_wdata = DATA_W'(w_req.wdata);

    // Capture the response of this cycle's handshake (or clear it when idle).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp_valid <= 2'b00;
            r_resp       <= '0;
        end else begin
            r_resp_valid <= w_grant;
            r_resp       <= w_resp_d;
        end
    end

    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_err   = r_resp.err;
    assign bus.resp_rdata = DATA_W'(r_resp.rdata);

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Directed self-checking bench for dmem_arbiter with a simple
//               behavioural 1024 x 64-bit memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam logic [63:0] c_d_store = 64'hDEAD_BEEF_0123_4567;
    localparam logic [63:0] c_w0      = 64'h1111_1111_1111_1111;
    localparam logic [63:0] c_w1      = 64'h2222_2222_2222_2222;
    localparam logic [63:0] c_w2      = 64'h3333_3333_3333_3333;
    localparam logic [63:0] c_wlast   = 64'hCAFE_F00D_0000_1FF8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic preload = 1'b1;
    int   tests = 0;
    int   fails = 0;

    logic [63:0] mem [0:1023];

    dmem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

    dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .DEPTH(1024)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural memory: combinational read, write at the clock edge.
    assign bus.mem_rdata = (bus.mem_addr < 64'h2000) ? mem[bus.mem_addr[12:3]] : 64'h0;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 64'h0;
            mem[0]    <= c_w0;
            mem[1]    <= c_w1;
            mem[2]    <= c_w2;
            mem[1023] <= c_wlast;
        end else if (bus.mem_write) begin
            mem[bus.mem_addr[12:3]] <= bus.mem_wdata;
        end
    end

    task automatic drive(input logic [1:0] v, input logic [1:0] we,
                         input logic [63:0] a0, input logic [63:0] a1,
                         input logic [63:0] d0, input logic [63:0] d1);
        bus.req_valid  = v;
        bus.req_we     = we;
        bus.req_addr0  = a0;
        bus.req_addr1  = a1;
        bus.req_wdata0 = d0;
        bus.req_wdata1 = d1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(2'b11, 2'b00, 64'h0, 64'h8, 64'h0, 64'h0);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            tests++; if (bus.req_ready !== 2'b00) begin fails++; $display("FAIL reset_ready cyc%0d: got %b want 00", i, bus.req_ready); end
            tests++; if ({bus.mem_read, bus.mem_write} !== 2'b00) begin fails++; $display("FAIL reset_mem_en cyc%0d: got %b want 00", i, {bus.mem_read, bus.mem_write}); end
            next_cycle();
        end
        tests++; if (bus.resp_valid !== 2'b00 || bus.resp_err !== 1'b0 || bus.resp_rdata !== 64'h0) begin
            fails++; $display("FAIL reset_resp: valid %b err %b rdata %h want 0/0/0", bus.resp_valid, bus.resp_err, bus.resp_rdata); end
        rst = 1'b0;
        #1;
        tests++; if (bus.req_ready !== 2'b01) begin fails++; $display("FAIL reset_first_grant: got %b want 01", bus.req_ready); end
        tests++; if (bus.mem_read !== 1'b1 || bus.mem_addr !== 64'h0) begin fails++; $display("FAIL reset_first_read: rd %b addr %h want 1/0", bus.mem_read, bus.mem_addr); end
        next_cycle();
        drive(2'b00, 2'b00, 64'h0, 64'h0, 64'h0, 64'h0);
        tests++; if (bus.resp_valid !== 2'b01 || bus.resp_rdata !== c_w0) begin
            fails++; $display("FAIL reset_first_resp: valid %b rdata %h want 01/%h", bus.resp_valid, bus.resp_rdata, c_w0); end
        next_cycle();
        tests++; if (bus.resp_valid !== 2'b00 || bus.resp_rdata !== 64'h0) begin
            fails++; $display("FAIL idle_resp: valid %b rdata %h want 00/0", bus.resp_valid, bus.resp_rdata); end
    endtask

    task automatic test_back_to_back();
        drive(2'b10, 2'b00, 64'h0, 64'h8, 64'h0, 64'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if (bus.req_ready !== 2'b10) begin fails++; $display("FAIL b2b_ready cyc%0d: got %b want 10", i, bus.req_ready); end
            next_cycle();
            tests++; if (bus.resp_valid !== 2'b10 || bus.resp_rdata !== c_w1) begin
                fails++; $display("FAIL b2b_resp cyc%0d: valid %b rdata %h want 10/%h", i, bus.resp_valid, bus.resp_rdata, c_w1); end
        end
        drive(2'b00, 2'b00, 64'h0, 64'h0, 64'h0, 64'h0);
        next_cycle();
    endtask

    task automatic test_store_load();
        drive(2'b10, 2'b10, 64'h0, 64'h40, 64'h0, c_d_store);
        #1;
        tests++; if (bus.req_ready !== 2'b10 || bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0) begin
            fails++; $display("FAIL st_drive: ready %b wr %b rd %b want 10/1/0", bus.req_ready, bus.mem_write, bus.mem_read); end
        tests++; if (bus.mem_addr !== 64'h40 || bus.mem_wdata !== c_d_store) begin
            fails++; $display("FAIL st_bus: addr %h wdata %h want 40/%h", bus.mem_addr, bus.mem_wdata, c_d_store); end
        next_cycle();
        drive(2'b10, 2'b00, 64'h0, 64'h40, 64'h0, 64'h0);
        tests++; if (bus.resp_valid !== 2'b10 || bus.resp_err !== 1'b0 || bus.resp_rdata !== 64'h0) begin
            fails++; $display("FAIL st_resp: valid %b err %b rdata %h want 10/0/0", bus.resp_valid, bus.resp_err, bus.resp_rdata); end
        #1;
        tests++; if (bus.mem_read !== 1'b1) begin fails++; $display("FAIL ld_read_en: got %b want 1", bus.mem_read); end
        next_cycle();
        drive(2'b00, 2'b00, 64'h0, 64'h0, 64'h0, 64'h0);
        tests++; if (bus.resp_valid !== 2'b10 || bus.resp_err !== 1'b0 || bus.resp_rdata !== c_d_store) begin
            fails++; $display("FAIL raw_resp: valid %b err %b rdata %h want 10/0/%h", bus.resp_valid, bus.resp_err, bus.resp_rdata, c_d_store); end
        next_cycle();
    endtask

    task automatic test_contention();
        logic [1:0]  exp_g [4];
        logic [63:0] exp_d [4];
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
        exp_d[0] = c_w0;  exp_d[1] = c_w1;  exp_d[2] = c_w0;  exp_d[3] = c_w1;
        drive(2'b11, 2'b00, 64'h0, 64'h8, 64'h0, 64'h0);
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++; if (bus.req_ready !== exp_g[i]) begin fails++; $display("FAIL cont_grant cyc%0d: got %b want %b", i, bus.req_ready, exp_g[i]); end
            next_cycle();
            if (i == 3) drive(2'b00, 2'b00, 64'h0, 64'h0, 64'h0, 64'h0);
            tests++; if (bus.resp_valid !== exp_g[i] || bus.resp_rdata !== exp_d[i] || bus.resp_err !== 1'b0) begin
                fails++; $display("FAIL cont_resp cyc%0d: valid %b rdata %h want %b/%h", i, bus.resp_valid, bus.resp_rdata, exp_g[i], exp_d[i]); end
        end
        next_cycle();
    endtask

    task automatic test_misaligned();
        drive(2'b10, 2'b10, 64'h0, 64'h44, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
        #1;
        tests++; if (bus.req_ready !== 2'b10 || bus.mem_write !== 1'b0 || bus.mem_read !== 1'b0) begin
            fails++; $display("FAIL mis_drive: ready %b wr %b rd %b want 10/0/0", bus.req_ready, bus.mem_write, bus.mem_read); end
        next_cycle();
        drive(2'b10, 2'b00, 64'h0, 64'h40, 64'h0, 64'h0);
        tests++; if (bus.resp_valid !== 2'b10 || bus.resp_err !== 1'b1 || bus.resp_rdata !== 64'h0) begin
            fails++; $display("FAIL mis_resp: valid %b err %b rdata %h want 10/1/0", bus.resp_valid, bus.resp_err, bus.resp_rdata); end
        next_cycle();
        drive(2'b00, 2'b00, 64'h0, 64'h0, 64'h0, 64'h0);
        tests++; if (bus.resp_err !== 1'b0 || bus.resp_rdata !== c_d_store) begin
            fails++; $display("FAIL mis_unchanged: err %b rdata %h want 0/%h", bus.resp_err, bus.resp_rdata, c_d_store); end
        next_cycle();
    endtask

    task automatic test_out_of_range();
        drive(2'b01, 2'b00, 64'h2000, 64'h0, 64'h0, 64'h0);
        #1;
        tests++; if (bus.req_ready !== 2'b01 || bus.mem_read !== 1'b0) begin
            fails++; $display("FAIL oor_drive: ready %b rd %b want 01/0", bus.req_ready, bus.mem_read); end
        next_cycle();
        drive(2'b01, 2'b00, 64'h1FF8, 64'h0, 64'h0, 64'h0);
        tests++; if (bus.resp_valid !== 2'b01 || bus.resp_err !== 1'b1 || bus.resp_rdata !== 64'h0) begin
            fails++; $display("FAIL oor_resp: valid %b err %b rdata %h want 01/1/0", bus.resp_valid, bus.resp_err, bus.resp_rdata); end
        #1;
        tests++; if (bus.mem_read !== 1'b1) begin fails++; $display("FAIL top_read_en: got %b want 1", bus.mem_read); end
        next_cycle();
        drive(2'b00, 2'b00, 64'h0, 64'h0, 64'h0, 64'h0);
        tests++; if (bus.resp_err !== 1'b0 || bus.resp_rdata !== c_wlast) begin
            fails++; $display("FAIL top_resp: err %b rdata %h want 0/%h", bus.resp_err, bus.resp_rdata, c_wlast); end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        drive(2'b01, 2'b01, 64'h10, 64'h0, 64'h5555_5555_5555_5555, 64'h0);
        rst = 1'b1;
        #1;
        tests++; if (bus.req_ready !== 2'b00 || bus.mem_write !== 1'b0) begin
            fails++; $display("FAIL rmid_drive: ready %b wr %b want 00/0", bus.req_ready, bus.mem_write); end
        next_cycle();
        rst = 1'b0;
        drive(2'b11, 2'b00, 64'h10, 64'h8, 64'h0, 64'h0);
        tests++; if (bus.resp_valid !== 2'b00) begin fails++; $display("FAIL rmid_resp: valid %b want 00", bus.resp_valid); end
        tests++; if (mem[2] !== c_w2) begin fails++; $display("FAIL rmid_mem: got %h want %h", mem[2], c_w2); end
        #1;
        tests++; if (bus.req_ready !== 2'b01) begin fails++; $display("FAIL rmid_grant: got %b want 01", bus.req_ready); end
        next_cycle();
        drive(2'b00, 2'b00, 64'h0, 64'h0, 64'h0, 64'h0);
        tests++; if (bus.resp_valid !== 2'b01 || bus.resp_rdata !== c_w2) begin
            fails++; $display("FAIL rmid_load: valid %b rdata %h want 01/%h", bus.resp_valid, bus.resp_rdata, c_w2); end
        next_cycle();
    endtask

    initial begin
        drive(2'b00, 2'b00, 64'h0, 64'h0, 64'h0, 64'h0);
        next_cycle();
        preload = 1'b0;
        test_reset();
        test_back_to_back();
        test_store_load();
        test_contention();
        test_misaligned();
        test_out_of_range();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_dmem_arbiter
`default_nettype wire
